pc_sequencer: RTL and testbench

Program-counter stage of the single-cycle processor. Holds the 8-bit PC that addresses instruction memory and computes the next PC each cycle. The next PC is chosen from four sources: sequential increment, PC-relative branch, absolute jump, and call/return through a small hardware return-address stack. It feeds the fetch path and the increment/branch-target adders, and sits directly upstream of them.

---
 rtl/pc_sequencer_pkg.sv | 22 ++
 rtl/pc_sequencer_return_stack.sv | 60 ++++++
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: next-PC select ops and FSM states.
package pc_sequencer_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned STATE_W = 2;

    // Next-PC select; codes 5..7 are unused and fall back to sequential.
    typedef enum logic [OP_W-1:0] {
        OP_SEQ    = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JUMP   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } op_e;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Hardware return-address stack: LIFO of DEPTH entries, pointer reset only.
module return_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned SP_W  = IDX_W + 1;

    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic [SP_W-1:0]  sp_m1;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Pointer decode: write at sp, read the most recent entry at sp-1.
    always_comb begin
        full     = (sp_q == SP_W'(DEPTH));
        empty    = (sp_q == '0);
        sp_m1    = sp_q - SP_W'(1);
        wr_idx   = sp_q[IDX_W-1:0];
        rd_idx   = sp_m1[IDX_W-1:0];
        pop_data = mem_q[rd_idx];
    end

    // Push/pop update; requests against a full/empty stack are dropped.
    always_comb begin
        sp_d  = sp_q;
        mem_d = mem_q;
        if (push && !full) begin
            mem_d[wr_idx] = push_data;
            sp_d          = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_m1;
        end
    end

    // Stack pointer with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sp_q <= '0;
        else          sp_q <= sp_d;
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: FSM, next-PC mux, PC register and return stack.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       WIDTH        = 8,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(0),
    parameter int unsigned       STACK_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             halt,
    input  logic [OP_W-1:0]  op,
    input  logic             take,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus1,
    output logic             halted,
    output logic             stack_err
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             halted_q;
    logic             halted_d;
    logic             stack_err_q;
    logic             stack_err_d;

    logic             active_c;
    logic             fault_c;
    logic             push_c;
    logic             pop_c;
    logic             stk_full;
    logic             stk_empty;
    logic [WIDTH-1:0] stk_pop_data;

    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_c),
        .pop       (pop_c),
        .push_data (pc_plus1),
        .pop_data  (stk_pop_data),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // An op is live on an advancing cycle outside HALTED; halt masks faults.
    always_comb begin
        pc_plus1 = pc_q + WIDTH'(1);
        active_c = run && (state_q != S_HALTED);
        fault_c  = active_c && !halt &&
                   (((op == OP_CALL) && stk_full) || ((op == OP_RET) && stk_empty));
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state: the first advancing edge leaves IDLE; halt or fault stops for good.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (run) begin
                    if (halt || fault_c) state_d = S_HALTED;
                    else                 state_d = S_RUN;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_HALTED;
        endcase
    end

    // Next-PC mux, stack requests and sticky flags.
    always_comb begin
        pc_d        = pc_q;
        push_c      = 1'b0;
        pop_c       = 1'b0;
        stack_err_d = stack_err_q;
        halted_d    = (state_d == S_HALTED);
        if (active_c && !halt) begin
            if (fault_c) begin
                stack_err_d = 1'b1;
            end else begin
                case (op)
                    OP_BRANCH: pc_d = take ? (pc_q + offset) : pc_plus1;
                    OP_JUMP:   pc_d = target;
                    OP_CALL: begin
                        push_c = 1'b1;
                        pc_d   = target;
                    end
                    OP_RET: begin
                        pop_c = 1'b1;
                        pc_d  = stk_pop_data;
                    end
                    default:   pc_d = pc_plus1;
                endcase
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_VECTOR;
            halted_q    <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            halted_q    <= halted_d;
            stack_err_q <= stack_err_d;
        end
    end

    assign pc        = pc_q;
    assign halted    = halted_q;
    assign stack_err = stack_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer against a queue-based behavioural model.
module tb_pc_sequencer;

    localparam int SEQ = 0, BR = 1, JMP = 2, CALL = 3, RET = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run, halt, take;
    logic [2:0] op;
    logic [7:0] offset, target;
    logic [7:0] pc, pc_plus1;
    logic       halted, stack_err;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .halt      (halt),
        .op        (op),
        .take      (take),
        .offset    (offset),
        .target    (target),
        .pc        (pc),
        .pc_plus1  (pc_plus1),
        .halted    (halted),
        .stack_err (stack_err)
    );

    typedef struct {
        int pc;
        bit halted;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int m_pc;
    bit m_halted;
    bit m_err;
    int m_stack[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 0;
        m_halted = 0;
        m_err = 0;
        m_stack.delete();
    endfunction

    function automatic void model_fault();
        m_err = 1;
        m_halted = 1;
    endfunction

    function automatic void model_step(input bit r, input bit h, input int o,
                                       input bit t, input int off, input int tgt);
        int d;
        if (!r || m_halted) return;
        if (h) begin
            m_halted = 1;
            return;
        end
        case (o)
            BR: begin
                d = (off >= 128) ? off - 256 : off;
                m_pc = t ? (m_pc + d + 256) % 256 : (m_pc + 1) % 256;
            end
            JMP: m_pc = tgt;
            CALL: begin
                if (m_stack.size() == DEPTH) model_fault();
                else begin
                    m_stack.push_back((m_pc + 1) % 256);
                    m_pc = tgt;
                end
            end
            RET: begin
                if (m_stack.size() == 0) model_fault();
                else m_pc = m_stack.pop_back();
            end
            default: m_pc = (m_pc + 1) % 256;
        endcase
    endfunction

    // Drive one cycle, update the model at the edge and queue the expectation.
    task automatic step(input bit r, input bit h, input int o, input bit t,
                        input int off, input int tgt);
        exp_t e;
        run = r; halt = h; op = 3'(o); take = t;
        offset = 8'(off); target = 8'(tgt);
        @(posedge clk);
        model_step(r, h, o, t, off, tgt);
        e.pc = m_pc; e.halted = m_halted; e.err = m_err;
        exp_q.push_back(e);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("reset_pc", 32'(pc), 32'h00);
        check("reset_halted", 32'(halted), 32'h0);
        check("reset_err", 32'(stack_err), 32'h0);
        model_reset();
        exp_q.delete();
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: every cycle that has a pending expectation is compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", 32'(pc), 32'(e.pc));
                check("pc_plus1", 32'(pc_plus1), 32'((e.pc + 1) % 256));
                check("halted", 32'(halted), 32'(e.halted));
                check("stack_err", 32'(stack_err), 32'(e.err));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rets[4];
        reset_n = 1'b0;
        run = 0; halt = 0; op = 3'd0; take = 0; offset = 8'h00; target = 8'h00;
        model_reset();
        do_reset();

        // Sequential counting from reset
        repeat (3) step(1, 0, SEQ, 0, 0, 0);

        // Wrap-around and branches
        step(1, 0, JMP, 0, 0, 8'hFF);
        step(1, 0, SEQ, 0, 0, 0);
        step(1, 0, JMP, 0, 0, 8'h10);
        step(1, 0, BR, 1, 8'hF8, 0);
        step(1, 0, JMP, 0, 0, 8'h10);
        step(1, 0, BR, 0, 8'hF8, 0);
        step(1, 0, JMP, 0, 0, 8'h02);
        step(1, 0, BR, 1, 8'hFC, 0);
        step(1, 0, BR, 1, 8'h05, 0);

        // Call and return
        step(1, 0, JMP, 0, 0, 8'h05);
        step(1, 0, CALL, 0, 0, 8'h40);
        step(1, 0, RET, 0, 0, 0);

        // Four nested calls, four returns
        for (int i = 0; i < 4; i++) step(1, 0, CALL, 0, 0, 8'h20 + 8 * i);
        for (int i = 0; i < 4; i++) step(1, 0, RET, 0, 0, 0);

        // Stall holds everything
        repeat (5) step(0, 0, JMP, 0, 0, $urandom_range(0, 255));
        step(1, 0, SEQ, 0, 0, 0);

        // Randomised traffic, restarting whenever the model halts
        for (int i = 0; i < 400; i++) begin
            if (m_halted) do_reset();
            step($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 255), $urandom_range(0, 255));
        end

        // Overflow on the fifth call, then everything is ignored
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rets[i % 4] = i;
            step(1, 0, CALL, 0, 0, 8'h30 + i);
        end
        step(1, 0, JMP, 0, 0, 8'h77);
        step(1, 0, RET, 0, 0, 0);
        step(1, 0, SEQ, 0, 0, 0);

        // Underflow straight out of reset
        do_reset();
        step(1, 0, RET, 0, 0, 0);
        step(1, 0, SEQ, 0, 0, 0);

        // Halt suppresses a simultaneous jump
        do_reset();
        step(1, 0, JMP, 0, 0, 8'h33);
        step(1, 1, JMP, 0, 0, 8'h80);
        step(1, 0, JMP, 0, 0, 8'h80);

        // Reset while halted with two entries stacked, then underflow
        do_reset();
        step(1, 0, CALL, 0, 0, 8'h50);
        step(1, 0, CALL, 0, 0, 8'h60);
        step(1, 1, SEQ, 0, 0, 0);
        step(1, 0, SEQ, 0, 0, 0);
        do_reset();
        step(1, 0, RET, 0, 0, 0);
        step(1, 0, SEQ, 0, 0, 0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
